lsu_ctrl: RTL and testbench

Load/store unit between the single-cycle datapath and a handshaked data-memory bus. Takes the ALU-computed address, store data and func3 from the datapath. Performs byte-lane steering, sign/zero extension and alignment checking, then runs a request/acknowledge transaction. Stalls the core (PC and register write) until the access completes.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_if.sv | 20 ++
 rtl/lsu_align.sv | 60 ++++++
 rtl/lsu_ctrl.sv | 159 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// func3 access codes and the default bus timeout.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/lsu_if.sv
// Handshaked data-memory bus between lsu_ctrl (master) and memory (slave).
interface lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store replication, legality
// check and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        illegal,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_word[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? rdata_word[31:16] : rdata_word[15:0];

    always_comb begin
        be        = '0;
        wdata_rep = wdata;
        illegal   = 1'b0;
        case (func3[1:0])
            2'b00: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                illegal   = off[0];
            end
            2'b10: begin
                be      = 4'b1111;
                illegal = (off != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        // Stores have no unsigned variants; loads reject 11x.
        if (is_store ? func3[2] : (func3[2] & func3[1]))
            illegal = 1'b1;
    end

    always_comb begin
        ld_data = '0;
        case (func3)
            F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   ld_data = rdata_word;
            F3_LBU:  ld_data = {24'b0, byte_sel};
            F3_LHU:  ld_data = {16'b0, half_sel};
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM: registers the bus request, stalls the core until ack.
// Define LSU_TIMEOUT_EN to abort requests that see no ack for TIMEOUT_CYC cycles.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    lsu_if.master       bus
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;

    logic        access, in_idle, illegal;
    logic [1:0]  off_sel;
    logic [2:0]  f3_sel;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_ld;

    assign access  = mem_rd | mem_wr;
    assign in_idle = (state_q == IDLE);
    // Lane offset and size are live in IDLE, then frozen for the load return.
    assign off_sel = in_idle ? addr[1:0] : off_q;
    assign f3_sel  = in_idle ? func3 : f3_q;

    lsu_align u_align (
        .off        (off_sel),
        .func3      (f3_sel),
        .is_store   (mem_wr),
        .wdata      (wdata),
        .rdata_word (bus.bus_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata),
        .illegal    (illegal),
        .ld_data    (al_ld)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        off_d   = off_q;
        f3_d    = f3_q;
        rdata_d = '0;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (access && !illegal) begin
                    state_d = REQ;
                    addr_d  = {addr[31:2], 2'b00};
                    be_d    = al_be;
                    wdata_d = mem_wr ? al_wdata : '0;
                    we_d    = mem_wr;
                    off_d   = addr[1:0];
                    f3_d    = func3;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                if (bus.bus_ack) begin
                    state_d = DONE;
                    rdata_d = we_q ? '0 : al_ld;
                end else begin
`ifdef LSU_TIMEOUT_EN
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign bus.bus_req   = (state_q == REQ);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign rdata         = rdata_q;
    assign stall         = (in_idle && access && !illegal) || (state_q == REQ);
    assign misalign      = in_idle && access && illegal;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed plan items plus randomized
// accesses checked against an arithmetic model of lane steering/extension.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd, mem_wr;
    logic [2:0]  func3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misalign, bus_err;

    int checks = 0;
    int errors = 0;

    lsu_if bus ();

    lsu_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .func3    (func3),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .misalign (misalign),
        .bus_err  (bus_err),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: access size in bytes, lane mask, per-lane store bytes and
    // shifted/masked/extended load word, all from plain arithmetic.
    function automatic void model(input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] mw, output logic legal,
                                  output logic [3:0] be, output logic [31:0] wrep,
                                  output logic [31:0] ld);
        int size, off;
        longint unsigned v, m;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2})
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        off   = int'(a % 4);
        if (legal && (off % size) != 0) legal = 1'b0;
        be = '0; wrep = '0; ld = '0;
        if (legal) begin
            be = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++)
                wrep[8*i +: 8] = 8'(wd >> (8 * (i % size)));
            m = (64'd1 << (8 * size)) - 1;
            v = (64'(mw) >> (8 * off)) & m;
            if (!st && f3 < 4 && size < 4 && v[8*size-1]) v = v | ~m;
            ld = 32'(v);
        end
    endfunction

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] mw, input int dly, input string tag,
                          output logic [31:0] got_rd, output logic [3:0] got_be,
                          output int n_stall);
        logic legal, st;
        logic [3:0] ebe;
        logic [31:0] ew, eld;
        st = wr;
        model(st, f3, a, wd, mw, legal, ebe, ew, eld);
        got_rd = '0; got_be = '0; n_stall = 0;
        @(negedge clk);
        mem_rd = rd; mem_wr = wr; func3 = f3; addr = a; wdata = wd;
        bus.bus_ack = 1'($urandom_range(0, 1));
        bus.bus_rdata = $urandom();
        #1;
        if (!(rd | wr)) begin
            chk({tag, ".nop_stall"}, stall, 0);
            chk({tag, ".nop_req"}, bus.bus_req, 0);
            chk({tag, ".nop_mis"}, misalign, 0);
            return;
        end
        chk({tag, ".idle_mis"}, misalign, !legal);
        chk({tag, ".idle_stall"}, stall, legal);
        chk({tag, ".idle_req"}, bus.bus_req, 0);
        chk({tag, ".idle_rdata"}, rdata, 0);
        if (stall) n_stall++;
        if (!legal) begin
            @(negedge clk);
            bus.bus_ack = 1'b0;
            #1;
            chk({tag, ".ill_req"}, bus.bus_req, 0);
            chk({tag, ".ill_rdata"}, rdata, 0);
            chk({tag, ".ill_stall"}, stall, 0);
            mem_rd = 1'b0; mem_wr = 1'b0;
            return;
        end
        for (int w = 0; w <= dly; w++) begin
            @(negedge clk);
            bus.bus_ack = (w == dly);
            bus.bus_rdata = (w == dly) ? mw : $urandom();
            #1;
            chk({tag, ".req"}, bus.bus_req, 1);
            chk({tag, ".req_stall"}, stall, 1);
            chk({tag, ".addr"}, bus.bus_addr, {a[31:2], 2'b00});
            chk({tag, ".be"}, bus.bus_be, ebe);
            chk({tag, ".we"}, bus.bus_we, st);
            chk({tag, ".req_rdata"}, rdata, 0);
            if (st) chk({tag, ".wdata"}, bus.bus_wdata, ew);
            if (stall) n_stall++;
            got_be = bus.bus_be;
        end
        @(negedge clk);
        bus.bus_ack = 1'($urandom_range(0, 1));
        bus.bus_rdata = $urandom();
        #1;
        chk({tag, ".done_req"}, bus.bus_req, 0);
        chk({tag, ".done_stall"}, stall, 0);
        chk({tag, ".done_err"}, bus_err, 0);
        if (!st) chk({tag, ".done_rdata"}, rdata, eld);
        got_rd = rdata;
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  b;
        int          ns, n;
        logic [31:0] ra;
        int          op;

        rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; func3 = '0;
        addr = '0; wdata = '0; bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.req", bus.bus_req, 0);
        chk("rst.we", bus.bus_we, 0);
        chk("rst.addr", bus.bus_addr, 0);
        chk("rst.be", bus.bus_be, 0);
        chk("rst.wdata", bus.bus_wdata, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.err", bus_err, 0);
        chk("rst.stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        access(0, 1, F3_SW, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, "sw", r, b, ns);
        chk("sw.be_const", b, 4'b1111);
        chk("sw.nstall", ns, 2);
        access(1, 0, F3_LB, 32'h0000_0103, 0, 32'h80FF_0000, 0, "lb", r, b, ns);
        chk("lb.rdata_const", r, 32'hFFFF_FF80);
        chk("lb.be_const", b, 4'b1000);
        access(1, 0, F3_LBU, 32'h0000_0103, 0, 32'h80FF_0000, 0, "lbu", r, b, ns);
        chk("lbu.rdata_const", r, 32'h0000_0080);
        access(0, 1, F3_SH, 32'h0000_0202, 32'h0000_1234, 0, 1, "sh", r, b, ns);
        chk("sh.be_const", b, 4'b1100);
        access(1, 0, F3_LH, 32'h0000_0201, 0, 0, 0, "lh_mis", r, b, ns);
        chk("lh_mis.nstall", ns, 0);
        access(1, 0, F3_LW, 32'h0000_0300, 0, 32'hCAFE_F00D, 4, "lw_wait", r, b, ns);
        chk("lw_wait.nstall", ns, 6);
        chk("lw_wait.rdata_const", r, 32'hCAFE_F00D);
        access(1, 1, F3_SB, 32'h0000_0011, 32'h0000_00A5, 0, 0, "both", r, b, ns);
        chk("both.be_const", b, 4'b0010);
        access(0, 1, 3'b100, 32'h0000_0020, 32'h1, 0, 0, "st_ill", r, b, ns);
        access(1, 0, 3'b011, 32'h0000_0020, 0, 0, 0, "ld_ill", r, b, ns);

        // Reset in the middle of a request
        @(negedge clk);
        mem_rd = 1'b1; func3 = F3_LW; addr = 32'h0000_0500; bus.bus_ack = 1'b0;
        #1 chk("rstmid.idle_stall", stall, 1);
        @(negedge clk);
        #1 chk("rstmid.req", bus.bus_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.req_drop", bus.bus_req, 0);
        chk("rstmid.addr", bus.bus_addr, 0);
        chk("rstmid.be", bus.bus_be, 0);
        mem_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1, F3_SW, 32'h0000_0600, 32'h0BAD_F00D, 0, 0, "post_rst", r, b, ns);
        chk("post_rst.nstall", ns, 2);

`ifdef LSU_TIMEOUT_EN
        @(negedge clk);
        mem_rd = 1'b1; func3 = F3_LW; addr = 32'h0000_0700; bus.bus_ack = 1'b0;
        #1 chk("to.idle_stall", stall, 1);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus.bus_req) n++;
            else break;
        end
        chk("to.req_cycles", n, TO);
        chk("to.err", bus_err, 1);
        chk("to.rdata", rdata, 0);
        chk("to.stall", stall, 0);
        mem_rd = 1'b0;
        @(negedge clk);
        #1 chk("to.err_pulse", bus_err, 0);
`endif

        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 3));
            ra = $urandom();
            access(op == 1 || op == 3, op >= 2, 3'($urandom_range(0, 7)), ra,
                   $urandom(), $urandom(), int'($urandom_range(0, 3)), "rnd", r, b, ns);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
